// File: rtl/enc_mixer_pkg.sv
// enc_mixer_pkg: shared step sizes, synchroniser depth and step direction for the encoder mixer.
package enc_mixer_pkg;
    localparam int STEP_SLOW   = 1;
    localparam int STEP_FAST   = 4;
    localparam int SYNC_STAGES = 2;
    typedef enum logic {DIR_UP, DIR_DOWN} dir_e;
endpackage

// File: rtl/enc_pwm_mixer_if.sv
// enc_pwm_mixer_if: encoder pins in, PWM/level/period-sync out.
interface enc_pwm_mixer_if #(
    parameter int NUM_CH    = 3,
    parameter int PWM_WIDTH = 8
);
    logic [NUM_CH-1:0]           enc_a;
    logic [NUM_CH-1:0]           enc_b;
    logic [NUM_CH-1:0]           pwm_out;
    logic [NUM_CH*PWM_WIDTH-1:0] level_out;
    logic                        pwm_sync;
    modport master (output enc_a, enc_b, input pwm_out, level_out, pwm_sync);
    modport slave  (input enc_a, enc_b, output pwm_out, level_out, pwm_sync);
endinterface

// File: rtl/enc_channel.sv
// enc_channel: sync, debounce and decode one encoder into a saturating level.
// Step acceleration is generated only when ENC_MIXER_ACCEL_EN is defined.
module enc_channel
    import enc_mixer_pkg::*;
#(
    parameter int PWM_WIDTH    = 8,
    parameter int DEBOUNCE_CYC = 4,
    parameter int ACCEL_WINDOW = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enc_a_i,
    input  logic                 enc_b_i,
    output logic [PWM_WIDTH-1:0] level_o
);
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int LW = PWM_WIDTH + 1;
    // bit 0 carries phase A, bit 1 phase B
    logic [SYNC_STAGES-1:0][1:0] sync_q;
    logic [1:0]                  deb_q;
    logic [DW-1:0]               cnt_q [2];
    logic                        a_prev_q;
    logic [PWM_WIDTH-1:0]        level_q, level_d;
    logic                        step;
    dir_e                        dir;
    logic [LW-1:0]               amt, sum;
`ifdef ENC_MIXER_ACCEL_EN
    localparam int AW = $clog2(ACCEL_WINDOW + 1);
    // preset to the window so the first step after reset is slow
    logic [AW-1:0] acc_q;
    always_ff @(posedge clk) begin
        if (!rst_n) acc_q <= AW'(ACCEL_WINDOW);
        else if (step) acc_q <= '0;
        else if (acc_q != AW'(ACCEL_WINDOW)) acc_q <= acc_q + 1'b1;
    end
    assign amt = (acc_q < AW'(ACCEL_WINDOW)) ? LW'(STEP_FAST) : LW'(STEP_SLOW);
`else
    assign amt = LW'(STEP_SLOW);
`endif
    always_comb begin
        step    = deb_q[0] & ~a_prev_q;
        dir     = deb_q[1] ? DIR_DOWN : DIR_UP;
        sum     = (dir == DIR_UP) ? {1'b0, level_q} + amt : {1'b0, level_q} - amt;
        level_d = !step ? level_q : sum[PWM_WIDTH] ? {PWM_WIDTH{dir == DIR_UP}} : sum[PWM_WIDTH-1:0];
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q   <= '0;
            deb_q    <= '0;
            cnt_q    <= '{default: '0};
            a_prev_q <= 1'b0;
            level_q  <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], enc_b_i, enc_a_i};
            for (int k = 0; k < 2; k++) begin
                if (sync_q[SYNC_STAGES-1][k] == deb_q[k]) cnt_q[k] <= '0;
                else if (cnt_q[k] == DW'(DEBOUNCE_CYC - 1)) begin
                    deb_q[k] <= sync_q[SYNC_STAGES-1][k];
                    cnt_q[k] <= '0;
                end else cnt_q[k] <= cnt_q[k] + 1'b1;
            end
            a_prev_q <= deb_q[0];
            level_q  <= level_d;
        end
    end
    assign level_o = level_q;
endmodule

// File: rtl/enc_pwm_mixer.sv
// enc_pwm_mixer: N encoder channels feeding glitch-free PWM outputs from one shared counter.
// Define ENC_MIXER_ACCEL_EN to enable fast-turn step acceleration in every channel.
module enc_pwm_mixer
    import enc_mixer_pkg::*;
#(
    parameter int NUM_CH       = 3,
    parameter int PWM_WIDTH    = 8,
    parameter int DEBOUNCE_CYC = 4,
    parameter int ACCEL_WINDOW = 256
) (
    input logic            clk,
    input logic            rst_n,
    enc_pwm_mixer_if.slave mix
);
    logic [NUM_CH-1:0][PWM_WIDTH-1:0] level, active_q, active_d;
    logic [PWM_WIDTH-1:0]             cnt_q, cnt_d;
    logic [NUM_CH-1:0]                pwm_q, pwm_d;
    logic                             sync_q;
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        enc_channel #(
            .PWM_WIDTH   (PWM_WIDTH),
            .DEBOUNCE_CYC(DEBOUNCE_CYC),
            .ACCEL_WINDOW(ACCEL_WINDOW)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .enc_a_i(mix.enc_a[i]),
            .enc_b_i(mix.enc_b[i]),
            .level_o(level[i])
        );
    end
    // compare on next-state values so pwm_q lines up with cnt_q and active_q
    always_comb begin
        cnt_d    = cnt_q + 1'b1;
        active_d = (&cnt_q) ? level : active_q;
        for (int i = 0; i < NUM_CH; i++) pwm_d[i] = cnt_d < active_d[i];
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            active_q <= '0;
            pwm_q    <= '0;
            sync_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
            pwm_q    <= pwm_d;
            sync_q   <= (cnt_d == '0);
        end
    end
    assign mix.pwm_out   = pwm_q;
    assign mix.level_out = level;
    assign mix.pwm_sync  = sync_q;
endmodule

// File: tb/tb_enc_pwm_mixer.sv
// tb_enc_pwm_mixer: directed checks on a 3x8-bit mixer and a 5x4-bit mixer.
module tb_enc_pwm_mixer;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   passes = 0;
    always #5 clk = ~clk;

    enc_pwm_mixer_if #(.NUM_CH(3), .PWM_WIDTH(8)) if0 ();
    enc_pwm_mixer_if #(.NUM_CH(5), .PWM_WIDTH(4)) if1 ();

    enc_pwm_mixer #(.NUM_CH(3), .PWM_WIDTH(8), .DEBOUNCE_CYC(4), .ACCEL_WINDOW(256))
        dut0 (.clk(clk), .rst_n(rst_n), .mix(if0.slave));
    enc_pwm_mixer #(.NUM_CH(5), .PWM_WIDTH(4), .DEBOUNCE_CYC(4), .ACCEL_WINDOW(256))
        dut1 (.clk(clk), .rst_n(rst_n), .mix(if1.slave));

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic logic [31:0] lv(input int d, input int ch);
        return d == 0 ? 32'(if0.level_out[ch*8 +: 8]) : 32'(if1.level_out[ch*4 +: 4]);
    endfunction

    task automatic set_a(input int d, input int ch, input logic v);
        if (d == 0) if0.enc_a[ch] = v;
        else if1.enc_a[ch] = v;
    endtask

    task automatic set_b(input int d, input int ch, input logic v);
        if (d == 0) if0.enc_b[ch] = v;
        else if1.enc_b[ch] = v;
    endtask

    // one detent: B settles, A rises and falls; next A rise is gap cycles after this one
    task automatic detent(input int d, input int ch, input logic down, input int gap);
        set_b(d, ch, down);
        tick(8);
        set_a(d, ch, 1'b1);
        tick(8);
        set_a(d, ch, 1'b0);
        tick(gap - 16);
    endtask

    task automatic wait_sync();
        int n = 0;
        while (!if0.pwm_sync && n < 600) begin
            tick();
            n++;
        end
        chk("sync_wait_bounded", 32'(n < 600), 1);
    endtask

    // count high cycles per channel over one 256-cycle period starting at a sync sample
    task automatic measure(output int h[3], output int s);
        h = '{0, 0, 0};
        s = 0;
        for (int t = 0; t < 256; t++) begin
            for (int i = 0; i < 3; i++) h[i] += int'(if0.pwm_out[i]);
            s += int'(if0.pwm_sync);
            tick();
        end
    endtask

    initial begin
        int n;
        int h[3];
        int s;
        rst_n     = 1'b0;
        if0.enc_a = '1;
        if0.enc_b = '0;
        if1.enc_a = '1;
        if1.enc_b = '1;
        tick();
        if0.enc_a = '0;
        if0.enc_b = '1;
        if1.enc_a = '0;
        tick();
        if0.enc_a = '1;
        tick();
        chk("rst_level0", 32'(if0.level_out), 0);
        chk("rst_pwm0", 32'(if0.pwm_out), 0);
        chk("rst_sync0", 32'(if0.pwm_sync), 0);
        chk("rst_level1", 32'(if1.level_out), 0);
        chk("rst_pwm1", 32'(if1.pwm_out), 0);
        if0.enc_a = '0;
        if0.enc_b = '0;
        if1.enc_a = '0;
        if1.enc_b = '0;
        rst_n = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!if0.pwm_sync && n < 600);
        chk("first_sync_cycles", n, 256);
`ifndef ENC_MIXER_ACCEL_EN
        for (int k = 1; k <= 4; k++) begin
            set_a(0, 0, 1'b1);
            tick(6);
            chk("latency_before", lv(0, 0), k - 1);
            tick(1);
            chk("latency_after", lv(0, 0), k);
            tick(1);
            set_a(0, 0, 1'b0);
            tick(42);
        end
        chk("inc_ch1_idle", lv(0, 1), 0);
        chk("inc_ch2_idle", lv(0, 2), 0);
        repeat (260) detent(0, 1, 1'b0, 24);
        chk("sat_max", lv(0, 1), 255);
        detent(0, 1, 1'b0, 24);
        chk("sat_max_hold", lv(0, 1), 255);
        detent(0, 1, 1'b1, 24);
        chk("sat_max_dec", lv(0, 1), 254);
        repeat (3) detent(0, 2, 1'b1, 24);
        chk("sat_min", lv(0, 2), 0);
        set_b(0, 2, 1'b0);
        tick(10);
        repeat (3) begin
            set_a(0, 2, 1'b1);
            tick(3);
            set_a(0, 2, 1'b0);
            tick(3);
        end
        tick(10);
        chk("bounce_reject", lv(0, 2), 0);
        set_a(0, 2, 1'b1);
        tick(8);
        chk("bounce_stable", lv(0, 2), 1);
        set_a(0, 2, 1'b0);
        tick(10);
        repeat (32) detent(0, 0, 1'b0, 24);
        chk("lvl36", lv(0, 0), 36);
        wait_sync();
        wait_sync();
        set_a(0, 0, 1'b1);
        tick(7);
        chk("lvl37_midperiod", lv(0, 0), 37);
        tick(28);
        chk("pwm_old_cnt35", 32'(if0.pwm_out[0]), 1);
        tick(1);
        chk("pwm_old_cnt36", 32'(if0.pwm_out[0]), 0);
        set_a(0, 0, 1'b0);
        tick(10);
        wait_sync();
        measure(h, s);
        chk("pwm_duty37", h[0], 37);
        chk("pwm_sync_once", s, 1);
        detent(0, 1, 1'b0, 24);
        detent(0, 2, 1'b1, 24);
        chk("lvl255", lv(0, 1), 255);
        chk("lvl0", lv(0, 2), 0);
        wait_sync();
        wait_sync();
        measure(h, s);
        chk("pwm_duty255", h[1], 255);
        chk("pwm_duty0", h[2], 0);
        chk("pwm_duty37_again", h[0], 37);
        repeat (20) detent(1, 3, 1'b0, 24);
        chk("w4_sat15", lv(1, 3), 15);
        chk("w4_others_idle", 32'(if1.level_out & ~(20'hF << 12)), 0);
        detent(1, 3, 1'b1, 24);
        chk("w4_dec14", lv(1, 3), 14);
`else
        detent(0, 0, 1'b0, 100);
        chk("accel_first_slow", lv(0, 0), 1);
        detent(0, 0, 1'b0, 100);
        chk("accel_fast5", lv(0, 0), 5);
        detent(0, 0, 1'b0, 300);
        chk("accel_fast9", lv(0, 0), 9);
        detent(0, 0, 1'b0, 100);
        chk("accel_slow10", lv(0, 0), 10);
        detent(1, 0, 1'b0, 100);
        chk("w4_accel1", lv(1, 0), 1);
        detent(1, 0, 1'b0, 100);
        chk("w4_accel5", lv(1, 0), 5);
        repeat (2) detent(1, 0, 1'b0, 100);
        chk("w4_accel13", lv(1, 0), 13);
        detent(1, 0, 1'b0, 100);
        chk("w4_accel_clamp15", lv(1, 0), 15);
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
